// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the PC, reads the instruction ROM and buffers
// {pc, inst, bp} in a DEPTH-entry FIFO toward decode. Optional macro: FETCH_PREDICT_EN.
module fetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic [XLEN-1:0]          pc_rom,
   output logic                     rom_req_o,
   input  logic [XLEN-1:0]          inst_rom,
   input  logic                     flush_i,
   input  logic [XLEN-1:0]          flush_pc_i,
   output logic                     id_valid_o,
   input  logic                     id_ready_i,
   output logic [XLEN-1:0]          id_pc_o,
   output logic [XLEN-1:0]          id_inst_o,
   output logic                     id_bp_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] pc_q, pc_d, next_pc;
   logic [XLEN-1:0] pc_mem_q [DEPTH];
   logic [XLEN-1:0] pc_mem_d [DEPTH];
   logic [XLEN-1:0] inst_mem_q [DEPTH];
   logic [XLEN-1:0] inst_mem_d [DEPTH];
   logic            full, empty, push, pop, bp_new;

   // Handshake: an entry transfers to decode on a rising edge where id_valid_o and
   // id_ready_i are both high; id_* hold steady while valid until that edge or a flush.
   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign id_valid_o = !empty;
   assign pop        = id_valid_o & id_ready_i;
   assign rom_req_o  = !flush_i & (!full | pop);
   assign push       = rom_req_o;
   assign pc_rom     = pc_q;
   assign count_o    = count_q;
   assign id_pc_o    = pc_mem_q[rd_ptr_q];
   assign id_inst_o  = inst_mem_q[rd_ptr_q];

`ifdef FETCH_PREDICT_EN
   logic [6:0]      opcode;
   logic [XLEN-1:0] j_imm, b_imm;
   logic            is_jal, is_bwd_br;
   logic [DEPTH-1:0] bp_mem_q, bp_mem_d;

   // Static backward-taken / forward-not-taken; JAL always taken, JALR never.
   always_comb begin
      opcode    = inst_rom[6:0];
      j_imm     = XLEN'($signed({inst_rom[31], inst_rom[19:12], inst_rom[20],
                                 inst_rom[30:21], 1'b0}));
      b_imm     = XLEN'($signed({inst_rom[31], inst_rom[7], inst_rom[30:25],
                                 inst_rom[11:8], 1'b0}));
      is_jal    = (opcode == 7'b1101111);
      is_bwd_br = (opcode == 7'b1100011) && inst_rom[31];
      bp_new    = is_jal | is_bwd_br;
      if (is_jal)         next_pc = pc_q + j_imm;
      else if (is_bwd_br) next_pc = pc_q + b_imm;
      else                next_pc = pc_q + XLEN'(4);
   end

   always_comb begin
      bp_mem_d = bp_mem_q;
      if (push) bp_mem_d[wr_ptr_q] = bp_new;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bp_mem_q <= '0;
      else        bp_mem_q <= bp_mem_d;
   end

   assign id_bp_o = bp_mem_q[rd_ptr_q];
`else
   assign bp_new  = 1'b0;
   assign next_pc = pc_q + XLEN'(4);
   assign id_bp_o = 1'b0;
`endif

   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      pc_d       = pc_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
         pc_d     = flush_pc_i;
      end else begin
         if (push) begin
            pc_mem_d[wr_ptr_q]   = pc_q;
            inst_mem_d[wr_ptr_q] = inst_rom;
            wr_ptr_d             = wr_ptr_q + AW'(1);
            pc_d                 = next_pc;
         end
         if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         pc_q       <= RESET_PC;
         pc_mem_q   <= '{default: '0};
         inst_mem_q <= '{default: '0};
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         pc_q       <= pc_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed phases push expected fetch pcs into exp_q,
// a negedge monitor pops and compares every accepted head entry.
module tb_fetch_queue;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FETCH_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif

  logic            clk, rst_n;
  logic [XLEN-1:0] pc_rom, inst_rom, flush_pc_i, id_pc_o, id_inst_o;
  logic            rom_req_o, flush_i, id_valid_o, id_ready_i, id_bp_o;
  logic [2:0]      count_o;

  int checks = 0;
  int errors = 0;
  int n_pops = 0;
  logic [XLEN-1:0] exp_q[$];

  fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .pc_rom(pc_rom), .rom_req_o(rom_req_o),
    .inst_rom(inst_rom), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o),
    .id_inst_o(id_inst_o), .id_bp_o(id_bp_o), .count_o(count_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM: 0x40 backward BEQ (-16), 0x80 forward BEQ (+16), else an ADDI-opcode word
  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'h40) return 32'hFE0008E3;
    if (a == 32'h80) return 32'h00000863;
    return {a[23:0], 8'h13};
  endfunction

  always_comb inst_rom = rom_f(pc_rom);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic exp_seq(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(start + 32'(4 * k));
  endtask

  // scoreboard monitor
  logic            prev_hold = 1'b0;
  logic [XLEN-1:0] prev_pc;
  logic [XLEN-1:0] e_pc;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("count_bound_valid", {31'b0, (count_o > 3'(DEPTH)) || (id_valid_o != (count_o != 0))}, 32'h0);
      if (prev_hold) chk("head_stable", id_pc_o, prev_pc);
      if (id_valid_o && id_ready_i && !flush_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", id_pc_o, 32'hFFFF_FFFF);
        end else begin
          e_pc = exp_q.pop_front();
          n_pops++;
          chk("pop_pc", id_pc_o, e_pc);
          chk("pop_inst", id_inst_o, rom_f(e_pc));
          chk("pop_bp", {31'b0, id_bp_o}, {31'b0, PRED && (e_pc == 32'h40)});
        end
      end
      prev_hold = id_valid_o && !id_ready_i && !flush_i;
      prev_pc   = id_pc_o;
    end else begin
      prev_hold = 1'b0;
    end
  end

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; flush_pc_i = '0; id_ready_i = 1'b0;
    repeat (2) tick();
    sample();
    chk("rst_pc_rom", pc_rom, 32'h0);
    chk("rst_count", {29'b0, count_o}, 32'h0);
    chk("rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("rst_id_pc", id_pc_o, 32'h0);
    chk("rst_id_inst", id_inst_o, 32'h0);
    chk("rst_bp", {31'b0, id_bp_o}, 32'h0);

    // fill with decode stalled
    tick(); rst_n = 1'b1; exp_seq(32'h0, 16);
    repeat (6) tick();
    sample();
    chk("fill_count", {29'b0, count_o}, 32'd4);
    chk("fill_pc_rom", pc_rom, 32'h10);
    chk("fill_req", {31'b0, rom_req_o}, 32'h0);
    chk("fill_head", id_pc_o, 32'h0);

    // full + pop in one cycle
    tick(); id_ready_i = 1'b1;
    sample();
    chk("fullpop_req", {31'b0, rom_req_o}, 32'h1);
    tick(); id_ready_i = 1'b0;
    sample();
    chk("fullpop_count", {29'b0, count_o}, 32'd4);
    chk("fullpop_pc_rom", pc_rom, 32'h14);
    chk("fullpop_head", id_pc_o, 32'h4);

    // flush, refill to 3, flush again with decode ready
    tick(); flush_i = 1'b1; flush_pc_i = 32'h100;
    sample();
    chk("flush_req", {31'b0, rom_req_o}, 32'h0);
    tick(); flush_i = 1'b0; exp_seq(32'h100, 8);
    sample();
    chk("flush1_count", {29'b0, count_o}, 32'h0);
    chk("flush1_pc_rom", pc_rom, 32'h100);
    repeat (3) tick();
    sample();
    chk("refill_count", {29'b0, count_o}, 32'd3);
    chk("refill_head", id_pc_o, 32'h100);
    tick(); flush_i = 1'b1; flush_pc_i = 32'h200; id_ready_i = 1'b1;
    tick(); flush_i = 1'b0; id_ready_i = 1'b0; exp_seq(32'h200, 8);
    sample();
    chk("flush2_count", {29'b0, count_o}, 32'h0);
    chk("flush2_valid", {31'b0, id_valid_o}, 32'h0);
    chk("flush2_pc_rom", pc_rom, 32'h200);
    tick();
    sample();
    chk("flush2_head_valid", {31'b0, id_valid_o}, 32'h1);
    chk("flush2_head_pc", id_pc_o, 32'h200);

    // prediction on a backward BEQ at 0x40
    tick(); flush_i = 1'b1; flush_pc_i = 32'h40;
    tick(); flush_i = 1'b0; exp_seq(32'h40, 1);
    sample();
    chk("bwd_pc_rom0", pc_rom, 32'h40);
    tick();
    sample();
    chk("bwd_next_pc", pc_rom, PRED ? 32'h30 : 32'h44);
    chk("bwd_head_pc", id_pc_o, 32'h40);
    chk("bwd_head_inst", id_inst_o, 32'hFE0008E3);
    chk("bwd_bp", {31'b0, id_bp_o}, {31'b0, PRED});

    // forward BEQ at 0x80 is never predicted
    tick(); flush_i = 1'b1; flush_pc_i = 32'h80;
    tick(); flush_i = 1'b0; exp_seq(32'h80, 1);
    tick();
    sample();
    chk("fwd_next_pc", pc_rom, 32'h84);
    chk("fwd_head_pc", id_pc_o, 32'h80);
    chk("fwd_bp", {31'b0, id_bp_o}, 32'h0);

    // random decode backpressure over a long sequential stream
    tick(); flush_i = 1'b1; flush_pc_i = 32'h200;
    tick(); flush_i = 1'b0; exp_seq(32'h200, 1100); n_pops = 0;
    for (int c = 0; c < 1000; c++) begin
      id_ready_i = 1'($urandom_range(0, 1));
      tick();
    end
    id_ready_i = 1'b0;
    sample();
    chk("rand_no_loss", 32'(n_pops), ((pc_rom - 32'h200) >> 2) - 32'(count_o));
    chk("rand_progress", {31'b0, n_pops > 300}, 32'h1);

    // async reset mid-stream
    tick(); id_ready_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_count", {29'b0, count_o}, 32'h0);
    chk("async_rst_valid", {31'b0, id_valid_o}, 32'h0);
    chk("async_rst_pc_rom", pc_rom, 32'h0);
    tick(); id_ready_i = 1'b0; rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
